// File: rtl/sysid_verify_pkg.sv
// rtl/sysid_verify_pkg.sv - shared types and constants for the system-ID verify sequencer
package sysid_verify_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    BACKOFF,
    DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'h582F_8372;

endpackage

// File: rtl/sysid_timeout_cnt.sv
// rtl/sysid_timeout_cnt.sv - saturating stall counter with expiry flag at LIMIT
module sysid_timeout_cnt #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (en && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the stall cycle that brings the count up to LIMIT, so the FSM
  // can leave the read on that same edge.
  assign expired = en && (cnt >= LIM_M1);

endmodule

// File: rtl/sysid_verify_ctrl.sv
// rtl/sysid_verify_ctrl.sv - post-reset system-ID read and compare sequencer
module sysid_verify_ctrl
  import sysid_verify_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  state_t     state;
  logic [3:0] retries;
  logic       auto_pend;
  logic       stall;
  logic       to_expired;

  assign stall = m_read && m_waitrequest;

  sysid_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (!stall),
    .en     (stall),
    .expired(to_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      retries         <= 4'd0;
      auto_pend       <= AUTO_START;
      m_address       <= 1'b0;
      m_read          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_code      <= ERR_NONE;
      id_value        <= 32'd0;
      timestamp_value <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start || auto_pend) begin
            auto_pend  <= 1'b0;
            state      <= RD_ID;
            m_read     <= 1'b1;
            m_address  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            error_code <= ERR_NONE;
            retries    <= 4'd0;
          end
        end
        RD_ID, RD_TS: begin
          if (!m_waitrequest) begin
            if (state == RD_ID) begin
              id_value  <= m_readdata;
              m_address <= 1'b1;
              state     <= RD_TS;
            end else begin
              timestamp_value <= m_readdata;
              m_read          <= 1'b0;
              m_address       <= 1'b0;
              state           <= CHECK;
            end
          end else if (to_expired) begin
            m_read    <= 1'b0;
            m_address <= 1'b0;
            if (retries < 4'(MAX_RETRIES)) begin
              retries <= retries + 4'd1;
              state   <= BACKOFF;
            end else begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              pass       <= 1'b0;
              error_code <= ERR_TIMEOUT;
            end
          end
        end
        BACKOFF: begin
          m_read    <= 1'b1;
          m_address <= 1'b0;
          state     <= RD_ID;
        end
        CHECK: begin
          // ID mismatch takes priority over a timestamp mismatch
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
          if (id_value != EXPECTED_ID) begin
            error_code <= ERR_ID;
          end else if (timestamp_value != EXPECTED_TIMESTAMP) begin
            error_code <= ERR_TS;
          end else begin
            error_code <= ERR_NONE;
            pass       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
